iguana_vga_dither: RTL and testbench

// - Output stage between the Cheshire VGA controller (wide RGB) and the narrow iguana VGA pads; replaces plain MSB truncation.
// - Applies a 4x4 ordered (Bayer) dither per colour channel, with an optional 2-bit frame-rotating temporal offset.
// - Registers RGB and both syncs so they stay aligned at the pads.

---
 rtl/iguana_pkg.sv | 24 ++
 rtl/iguana_vga_dither_chan.sv | 37 +++
 rtl/iguana_vga_dither.sv | 111 +++++++++++
 tb/tb_iguana_vga_dither.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iguana_pkg.sv
// Shared constants for the iguana VGA output stage: default pixel widths and
// the 4x4 ordered-dither (Bayer) threshold matrix.
package iguana_pkg;

    localparam int VgaRedWidth   = 5;
    localparam int VgaGreenWidth = 6;
    localparam int VgaBlueWidth  = 5;
    localparam int PadRedWidth   = 2;
    localparam int PadGreenWidth = 2;
    localparam int PadBlueWidth  = 2;

    // Row is selected by iy, column by ix.
    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    function automatic logic [3:0] bayer4(input logic [1:0] iy, input logic [1:0] ix);
        return BAYER4[iy][ix];
    endfunction

endpackage

// File: rtl/iguana_vga_dither_chan.sv
// One colour channel: keeps the upper bits and rounds up when the dropped
// remainder exceeds the Bayer threshold scaled to the remainder's width.
module iguana_vga_dither_chan #(
    parameter int InWidth  = 5,
    parameter int OutWidth = 2
) (
    input  logic [InWidth-1:0]  pixel,
    input  logic [3:0]          bayer,
    input  logic                dither_en,
    output logic [OutWidth-1:0] level
);

    localparam int D = InWidth - OutWidth;

    logic [OutWidth-1:0] hi;
    logic [D-1:0]        rem;
    logic [D+3:0]        threshold;
    logic                bump;

    function automatic logic [OutWidth-1:0] sat_inc(input logic [OutWidth-1:0] v,
                                                    input logic inc);
        if (inc && (v != '1)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    assign hi  = pixel[InWidth-1:D];
    assign rem = pixel[D-1:0];

    // B * 2^D / 16 covers both the left-shift (D>=4) and right-shift (D<4) cases.
    assign threshold = {bayer, {D{1'b0}}} >> 4;

    assign bump  = dither_en && ({4'b0000, rem} > threshold);
    assign level = sat_inc(hi, bump);

endmodule

// File: rtl/iguana_vga_dither.sv
// VGA pad output stage: pixel/line/frame counters driven by sync assertion
// edges select a Bayer threshold; RGB and syncs are registered together.
module iguana_vga_dither
    import iguana_pkg::*;
#(
    parameter int   InRedWidth     = VgaRedWidth,
    parameter int   InGreenWidth   = VgaGreenWidth,
    parameter int   InBlueWidth    = VgaBlueWidth,
    parameter int   OutRedWidth    = PadRedWidth,
    parameter int   OutGreenWidth  = PadGreenWidth,
    parameter int   OutBlueWidth   = PadBlueWidth,
    parameter int   PixShift       = 0,
    parameter logic SyncActiveHigh = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dither_en_i,
    input  logic                     temporal_en_i,
    input  logic                     hsync_i,
    input  logic                     vsync_i,
    input  logic [InRedWidth-1:0]    red_i,
    input  logic [InGreenWidth-1:0]  green_i,
    input  logic [InBlueWidth-1:0]   blue_i,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic [OutRedWidth-1:0]   red_o,
    output logic [OutGreenWidth-1:0] green_o,
    output logic [OutBlueWidth-1:0]  blue_o
);

    localparam int XW = 2 + PixShift;

    logic [XW-1:0] x_cnt;
    logic [1:0]    y_cnt;
    logic [1:0]    frame_cnt;
    logic          hsync_edge;
    logic          vsync_edge;
    logic [1:0]    ix;
    logic [1:0]    iy;
    logic [3:0]    bayer;

    logic [OutRedWidth-1:0]   red_d;
    logic [OutGreenWidth-1:0] green_d;
    logic [OutBlueWidth-1:0]  blue_d;

    // The registered sync outputs double as the previous-cycle sync levels.
    assign hsync_edge = (hsync_i == SyncActiveHigh) && (hsync_o != SyncActiveHigh);
    assign vsync_edge = (vsync_i == SyncActiveHigh) && (vsync_o != SyncActiveHigh);

    always_comb begin
        ix = x_cnt[PixShift +: 2];
        iy = y_cnt;
        if (temporal_en_i) begin
            ix = ix + frame_cnt;
            iy = iy + frame_cnt;
        end
    end

    assign bayer = bayer4(iy, ix);

    iguana_vga_dither_chan #(.InWidth(InRedWidth), .OutWidth(OutRedWidth)) u_red (
        .pixel     (red_i),
        .bayer     (bayer),
        .dither_en (dither_en_i),
        .level     (red_d)
    );

    iguana_vga_dither_chan #(.InWidth(InGreenWidth), .OutWidth(OutGreenWidth)) u_green (
        .pixel     (green_i),
        .bayer     (bayer),
        .dither_en (dither_en_i),
        .level     (green_d)
    );

    iguana_vga_dither_chan #(.InWidth(InBlueWidth), .OutWidth(OutBlueWidth)) u_blue (
        .pixel     (blue_i),
        .bayer     (bayer),
        .dither_en (dither_en_i),
        .level     (blue_d)
    );

    // Output stage: one register level for syncs, colour and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_cnt <= '0;
            hsync_o   <= ~SyncActiveHigh;
            vsync_o   <= ~SyncActiveHigh;
            red_o     <= '0;
            green_o   <= '0;
            blue_o    <= '0;
        end else begin
            x_cnt <= hsync_edge ? '0 : x_cnt + 1'b1;
            if (vsync_edge) begin
                y_cnt <= '0;
            end else if (hsync_edge) begin
                y_cnt <= y_cnt + 1'b1;
            end
            if (vsync_edge) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            hsync_o <= hsync_i;
            vsync_o <= vsync_i;
            red_o   <= red_d;
            green_o <= green_d;
            blue_o  <= blue_d;
        end
    end

endmodule

// File: tb/tb_iguana_vga_dither.sv
// Bench for iguana_vga_dither: table vectors, tile sweeps and a random run,
// all checked through a queue of expected outputs against an integer model.
module tb_iguana_vga_dither;

    logic       clk = 1'b0;
    logic       rst;
    logic       dither_en;
    logic       temporal_en;
    logic       hsync;
    logic       vsync;
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
    logic       hsync_o;
    logic       vsync_o;
    logic [1:0] red_o;
    logic [1:0] green_o;
    logic [1:0] blue_o;

    always #5 clk = ~clk;

    iguana_vga_dither dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dither_en_i   (dither_en),
        .temporal_en_i (temporal_en),
        .hsync_i       (hsync),
        .vsync_i       (vsync),
        .red_i         (red),
        .green_i       (green),
        .blue_i        (blue),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o)
    );

    typedef struct {
        logic       h;
        logic       v;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } exp_t;

    typedef struct {
        logic       h;
        logic       v;
        logic       de;
        logic       te;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic [2:0] mask;
        logic [1:0] er;
        logic [1:0] eg;
        logic [1:0] eb;
    } vec_t;

    exp_t q[$];
    vec_t tbl[12];

    int errors = 0;
    int checks = 0;

    int bayer[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
    int exp00[4] = '{1, 1, 1, 0};

    // Model state: counters and previous sync levels (active-low syncs).
    int   mx = 0;
    int   my = 0;
    int   mf = 0;
    logic mh_prev = 1'b1;
    logic mv_prev = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] chan(input int val, input int iw, input int bay, input logic de);
        int d;
        int hi;
        int r;
        int t;
        d  = iw - 2;
        hi = val >> d;
        r  = val % (1 << d);
        t  = (bay << d) / 16;
        if (de && (r > t) && (hi < 3)) hi++;
        return 2'(hi);
    endfunction

    task automatic step(input logic h, input logic v, input logic de, input logic te,
                        input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                        input logic [2:0] mask, input logic [1:0] er, input logic [1:0] eg,
                        input logic [1:0] eb);
        exp_t e;
        exp_t got;
        int   ix;
        int   iy;
        logic he;
        logic ve;
        hsync = h; vsync = v; dither_en = de; temporal_en = te;
        red = r; green = g; blue = b;
        if (rst) begin
            e.h = 1'b1; e.v = 1'b1; e.r = 2'd0; e.g = 2'd0; e.b = 2'd0;
            mx = 0; my = 0; mf = 0; mh_prev = 1'b1; mv_prev = 1'b1;
        end else begin
            ix = mx; iy = my;
            if (te) begin
                ix = (ix + mf) % 4;
                iy = (iy + mf) % 4;
            end
            e.h = h; e.v = v;
            e.r = mask[2] ? er : chan(int'(r), 5, bayer[iy][ix], de);
            e.g = mask[1] ? eg : chan(int'(g), 6, bayer[iy][ix], de);
            e.b = mask[0] ? eb : chan(int'(b), 5, bayer[iy][ix], de);
            he = (h == 1'b0) && mh_prev;
            ve = (v == 1'b0) && mv_prev;
            mx = he ? 0 : (mx + 1) % 4;
            if (ve) my = 0;
            else if (he) my = (my + 1) % 4;
            if (ve) mf = (mf + 1) % 4;
            mh_prev = h; mv_prev = v;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("hsync", int'(hsync_o), int'(got.h));
        chk("vsync", int'(vsync_o), int'(got.v));
        chk("red",   int'(red_o),   int'(got.r));
        chk("green", int'(green_o), int'(got.g));
        chk("blue",  int'(blue_o),  int'(got.b));
    endtask

    // Four rows of four pixels; row 0 starts with a joint hsync+vsync edge.
    task automatic tile(input logic de, input logic te, input logic [4:0] r,
                        input logic [5:0] g, input logic [4:0] b,
                        output int n_r2, output int n_r3, output int n_g1,
                        output int n_g3, output int g00);
        n_r2 = 0; n_r3 = 0; n_g1 = 0; n_g3 = 0; g00 = 0;
        for (int y = 0; y < 4; y++) begin
            step(1'b1, (y == 0), de, te, r, g, b, 3'b000, 2'd0, 2'd0, 2'd0);
            step(1'b0, 1'b0, de, te, r, g, b, 3'b000, 2'd0, 2'd0, 2'd0);
            for (int x = 0; x < 4; x++) begin
                step(1'b0, 1'b0, de, te, r, g, b, 3'b000, 2'd0, 2'd0, 2'd0);
                if (red_o == 2'd2) n_r2++;
                if (red_o == 2'd3) n_r3++;
                if (green_o == 2'd1) n_g1++;
                if (green_o == 2'd3) n_g3++;
                if (x == 0 && y == 0) g00 = int'(green_o);
            end
        end
    endtask

    initial begin
        int n_r2;
        int n_r3;
        int n_g1;
        int n_g3;
        int g00;

        // Spatial pattern from (0,0), truncation, then the next row.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b000, 2'd0, 2'd0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b000, 2'd0, 2'd0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd2, 2'd2, 2'd3};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd1, 2'd1, 2'd3};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd2, 2'd2, 2'd3};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd1, 2'd1, 2'd3};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10111, 6'b110000, 5'b00111, 3'b111, 2'd2, 2'd3, 2'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b10111, 6'b110000, 5'b00111, 3'b111, 2'd2, 2'd3, 2'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b000, 2'd0, 2'd0, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b000, 2'd0, 2'd0, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd1, 2'd1, 2'd3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b01100, 6'b010111, 5'b11111, 3'b111, 2'd2, 2'd2, 2'd3};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 6'($urandom), 5'($urandom), 3'b000, 2'd0, 2'd0, 2'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].te, tbl[i].r, tbl[i].g, tbl[i].b,
                 tbl[i].mask, tbl[i].er, tbl[i].eg, tbl[i].eb);
        end

        // Truncation holds at every position.
        for (int i = 0; i < 10; i++) begin
            step(1'(i == 4), 1'b0, 1'b0, 1'b0, 5'b10111, 6'd0, 5'd0, 3'b100, 2'd2, 2'd0, 2'd0);
        end

        tile(1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, n_r2, n_r3, n_g1, n_g3, g00);
        chk("spatial_tile_red2", n_r2, 8);

        tile(1'b1, 1'b0, 5'b11111, 6'b111111, 5'b11111, n_r2, n_r3, n_g1, n_g3, g00);
        chk("sat_tile_red3", n_r3, 16);
        chk("sat_tile_green3", n_g3, 16);

        // Reset mid-line with syncs idle: counters restart from (0,0).
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b100, 2'd2, 2'd0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b100, 2'd1, 2'd0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b100, 2'd2, 2'd0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 5'b01100, 6'd0, 5'd0, 3'b100, 2'd1, 2'd0, 2'd0);

        // Temporal rotation over five frames from a freshly reset frame counter.
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 6'd0, 5'd0, 3'b000, 2'd0, 2'd0, 2'd0);
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            tile(1'b1, 1'b1, 5'd0, 6'b000101, 5'd0, n_r2, n_r3, n_g1, n_g3, g00);
            chk($sformatf("temporal_ones_f%0d", f), n_g1, 5);
            chk($sformatf("temporal_origin_f%0d", f), g00, exp00[(f + 1) % 4]);
        end

        // Random traffic including enable toggles and occasional resets.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            step(($urandom_range(0, 5) != 0), ($urandom_range(0, 15) != 0), 1'($urandom),
                 1'($urandom), 5'($urandom), 6'($urandom), 5'($urandom), 3'b000, 2'd0, 2'd0, 2'd0);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
